// File: rtl/multi_mode_ff_bank_if.sv
// multi_mode_ff_bank_if: control inputs and state outputs of the flip-flop bank
interface multi_mode_ff_bank_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             err_clr;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic [WIDTH-1:0] qprev;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] illegal;
   logic             err_sticky;
   logic [CNT_W-1:0] err_cnt;
   modport master (
      output en, mode, a, b, err_clr,
      input  q, qb, qprev, rise, fall, illegal, err_sticky, err_cnt
   );
   modport slave (
      input  en, mode, a, b, err_clr,
      output q, qb, qprev, rise, fall, illegal, err_sticky, err_cnt
   );
endinterface

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: bank of SR/JK/D/T flip-flops with edge pulses and illegal-SR tracking
module multi_mode_ff_bank #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input logic                clk,
   input logic                rst,
   multi_mode_ff_bank_if.slave bus
);
   logic [1:0]       rst_sync;
   logic             rst_i;
   logic [WIDTH-1:0] q, nxt, ill;
   logic             hit;
   // assertion passes straight through; release waits two clk edges
   always_ff @(posedge clk or negedge rst)
      if (!rst) rst_sync <= '0;
      else rst_sync <= {rst_sync[0], 1'b1};
   assign rst_i = rst_sync[1];
   always_comb begin
      nxt = bus.mode == 2'b00 ? (bus.a & ~bus.b) | (q & ~(bus.a ^ bus.b))
          : bus.mode == 2'b01 ? (bus.a & ~q) | (~bus.b & q)
          : bus.mode == 2'b10 ? bus.a
          : q ^ bus.a;
      ill = bus.mode == 2'b00 ? bus.a & bus.b : '0;
      hit = bus.en && |ill;
   end
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) begin
         q          <= '0;
         bus.qprev  <= '0;
         bus.rise   <= '0;
         bus.fall   <= '0;
         bus.illegal <= '0;
      end else if (bus.en) begin
         q          <= nxt;
         bus.qprev  <= q;
         bus.rise   <= ~q & nxt;
         bus.fall   <= q & ~nxt;
         bus.illegal <= ill;
      end else begin
         bus.rise   <= '0;
         bus.fall   <= '0;
         bus.illegal <= '0;
      end
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) begin
         bus.err_cnt    <= '0;
         bus.err_sticky <= 1'b0;
      end else if (bus.err_clr) begin
         bus.err_cnt    <= CNT_W'(hit);
         bus.err_sticky <= hit;
      end else if (hit) begin
         bus.err_cnt    <= &bus.err_cnt ? bus.err_cnt : bus.err_cnt + CNT_W'(1);
         bus.err_sticky <= 1'b1;
      end
   assign bus.q  = q;
   assign bus.qb = ~q;
endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// tb_multi_mode_ff_bank: directed vectors for the flip-flop bank, WIDTH=8, CNT_W=2
module tb_multi_mode_ff_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n   = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(2)) bus ();
   multi_mode_ff_bank #(.WIDTH(8), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input logic en, input logic [1:0] m, input logic [7:0] a,
                      input logic [7:0] b, input logic clr);
      bus.en = en; bus.mode = m; bus.a = a; bus.b = b; bus.err_clr = clr;
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.en = 1'b0; bus.mode = 2'b00; bus.a = '0; bus.b = '0; bus.err_clr = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_q", bus.q, 8'h00);
      chk("rst_qb", bus.qb, 8'hFF);
      chk("rst_qprev", bus.qprev, 8'h00);
      chk("rst_cnt", bus.err_cnt, 2'd0);
      chk("rst_sticky", bus.err_sticky, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) cyc(0, 2'b00, 8'h00, 8'h00, 0);
      cyc(1, 2'b00, 8'h0F, 8'hF0, 0);
      chk("sr_set_q", bus.q, 8'h0F);
      chk("sr_set_qb", bus.qb, 8'hF0);
      chk("sr_set_rise", bus.rise, 8'h0F);
      chk("sr_set_fall", bus.fall, 8'h00);
      cyc(1, 2'b00, 8'h00, 8'h00, 0);
      chk("sr_hold_q", bus.q, 8'h0F);
      chk("sr_hold_rise", bus.rise, 8'h00);
      chk("sr_hold_qprev", bus.qprev, 8'h0F);
      cyc(1, 2'b00, 8'h01, 8'h01, 0);
      chk("ill1_cnt", bus.err_cnt, 2'd1);
      chk("ill1_flag", bus.illegal, 8'h01);
      cyc(1, 2'b00, 8'h01, 8'h01, 0);
      chk("ill2_flag", bus.illegal, 8'h01);
      cyc(1, 2'b00, 8'h01, 8'h01, 0);
      chk("ill3_q", bus.q, 8'h0F);
      chk("ill3_flag", bus.illegal, 8'h01);
      chk("ill3_cnt", bus.err_cnt, 2'd3);
      chk("ill3_sticky", bus.err_sticky, 1'b1);
      cyc(0, 2'b00, 8'h01, 8'h01, 0);
      chk("en0_ill", bus.illegal, 8'h00);
      chk("en0_cnt", bus.err_cnt, 2'd3);
      cyc(0, 2'b00, 8'h00, 8'h00, 1);
      chk("clr_en0_cnt", bus.err_cnt, 2'd0);
      chk("clr_en0_sticky", bus.err_sticky, 1'b0);
      cyc(1, 2'b01, 8'hFF, 8'hFF, 0);
      chk("jk_tog_q", bus.q, 8'hF0);
      chk("jk_tog_fall", bus.fall, 8'h0F);
      chk("jk_tog_rise", bus.rise, 8'hF0);
      chk("jk_tog_qprev", bus.qprev, 8'h0F);
      chk("jk_tog_ill", bus.illegal, 8'h00);
      cyc(1, 2'b01, 8'h3C, 8'h00, 0);
      chk("jk_set_q", bus.q, 8'hFC);
      chk("jk_set_rise", bus.rise, 8'h0C);
      cyc(1, 2'b10, 8'h5A, 8'hFF, 0);
      chk("d_q", bus.q, 8'h5A);
      chk("d_rise", bus.rise, 8'h02);
      chk("d_fall", bus.fall, 8'hA4);
      cyc(1, 2'b10, 8'h00, 8'h00, 0);
      chk("d_clr_q", bus.q, 8'h00);
      cyc(1, 2'b11, 8'h01, 8'h00, 0);
      chk("t1_q", bus.q, 8'h01);
      chk("t1_rise", bus.rise, 8'h01);
      cyc(0, 2'b11, 8'h01, 8'h00, 0);
      chk("t2_q", bus.q, 8'h01);
      chk("t2_rise", bus.rise, 8'h00);
      chk("t2_fall", bus.fall, 8'h00);
      chk("t2_qprev", bus.qprev, 8'h00);
      cyc(1, 2'b11, 8'h01, 8'h00, 0);
      chk("t3_q", bus.q, 8'h00);
      chk("t3_fall", bus.fall, 8'h01);
      chk("t3_qprev", bus.qprev, 8'h01);
      cyc(1, 2'b11, 8'h01, 8'h00, 0);
      chk("t4_q", bus.q, 8'h01);
      repeat (5) cyc(1, 2'b00, 8'h01, 8'h01, 0);
      chk("sat_cnt", bus.err_cnt, 2'd3);
      chk("sat_sticky", bus.err_sticky, 1'b1);
      chk("sat_q", bus.q, 8'h01);
      cyc(1, 2'b00, 8'h01, 8'h01, 1);
      chk("clr_ill_cnt", bus.err_cnt, 2'd1);
      chk("clr_ill_sticky", bus.err_sticky, 1'b1);
      cyc(1, 2'b00, 8'h00, 8'h00, 1);
      chk("clr_cnt", bus.err_cnt, 2'd0);
      chk("clr_sticky", bus.err_sticky, 1'b0);
      cyc(1, 2'b00, 8'h01, 8'h01, 0);
      chk("reacc_cnt", bus.err_cnt, 2'd1);
      cyc(1, 2'b10, 8'hAA, 8'h00, 0);
      chk("modechg_q", bus.q, 8'hAA);
      chk("modechg_ill", bus.illegal, 8'h00);
      #2 rst = 1'b0;
      #1;
      chk("arst_q", bus.q, 8'h00);
      chk("arst_qb", bus.qb, 8'hFF);
      chk("arst_cnt", bus.err_cnt, 2'd0);
      chk("arst_qprev", bus.qprev, 8'h00);
      chk("arst_rise", bus.rise, 8'h00);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) cyc(0, 2'b11, 8'h00, 8'h00, 0);
      cyc(1, 2'b11, 8'h01, 8'h00, 0);
      chk("post_rst_q", bus.q, 8'h01);
      chk("post_rst_qprev", bus.qprev, 8'h00);
      chk("post_rst_rise", bus.rise, 8'h01);
      $display("== %0d vectors applied, %0d miscompares ==", n, bad);
      $finish;
   end
endmodule
